dmem_access_ctrl: RTL

//  Sequences all accesses to the synchronous single-port data memory and shares it between two

---
 rtl/dmem_access_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: shares one synchronous single-port data memory between the
// CPU load/store unit (c_*) and the debug/loader port (d_*). It decodes MIPS
// load/store opcodes, formats load data with sign/zero extension, and performs
// read-modify-write for sb/sh. Ports are granted round-robin, and only one
// access is outstanding at a time.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned lw/lh/lhu/sh
// with err, without touching memory.
module dmem_access_ctrl #(
  parameter int MEM_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic [5:0]        c_op,
  input  logic [31:0]       c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_ack,
  output logic [31:0]       c_rdata,
  output logic              c_err,
  input  logic              d_req,
  input  logic [5:0]        d_op,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [2:0] {IDLE, RD, RSP, MRG, WR, ERR} state_t;

  state_t             state, state_nxt;
  logic               gnt_d;
  logic               prio_d;
  logic [5:0]         op_q;
  logic [MEM_AW+1:0]  addr_q;
  logic [31:0]        wdata_q;

  logic               any_req, pick_d, sel_bad, access_done;
  logic [5:0]         sel_op;
  logic [MEM_AW+1:0]  sel_addr;
  logic [31:0]        sel_wdata;
  logic               resp_ack, resp_err;
  logic [31:0]        resp_rdata;

  // Address bits above the memory size are intentionally dropped (addresses wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^{c_addr[31:MEM_AW+2], d_addr[31:MEM_AW+2]};

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: is_legal = 1'b1;
      default:                                                  is_legal = 1'b0;
    endcase
  endfunction

  // Selects the addressed lane of a memory word and extends it to 32 bits.
  function automatic logic [31:0] load_format(input logic [5:0]  op,
                                              input logic [1:0]  lo,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   load_format = {{24{b[7]}}, b};
      OP_LBU:  load_format = {24'h0, b};
      OP_LH:   load_format = {{16{h[15]}}, h};
      OP_LHU:  load_format = {16'h0, h};
      default: load_format = word;
    endcase
  endfunction

  // Replaces the byte (sb) or halfword (sh) lane of the old word with store data.
  function automatic logic [31:0] store_merge(input logic [5:0]  op,
                                              input logic [1:0]  lo,
                                              input logic [31:0] word,
                                              input logic [31:0] data);
    store_merge = word;
    if (op == OP_SB) store_merge[{lo, 3'b000} +: 8] = data[7:0];
    else             store_merge[{lo[1], 4'b0000} +: 16] = data[15:0];
  endfunction

  // Round-robin pick between the two requesters and decode of the winner's request.
  always_comb begin
    any_req   = c_req | d_req;
    pick_d    = d_req & (~c_req | prio_d);
    sel_op    = pick_d ? d_op : c_op;
    sel_addr  = pick_d ? d_addr[MEM_AW+1:0] : c_addr[MEM_AW+1:0];
    sel_wdata = pick_d ? d_wdata : c_wdata;
    sel_bad   = ~is_legal(sel_op);
`ifdef DMEM_ALIGN_CHECK_EN
    if (sel_op == OP_LW && sel_addr[1:0] != 2'b00) sel_bad = 1'b1;
    if ((sel_op == OP_LH || sel_op == OP_LHU || sel_op == OP_SH) && sel_addr[0]) sel_bad = 1'b1;
`endif
  end

  assign access_done = (state == RSP) || (state == MRG) || (state == WR) || (state == ERR);

  // State register plus the latched copy of the granted request and the tie-break pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gnt_d   <= 1'b0;
      prio_d  <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        gnt_d   <= pick_d;
        op_q    <= sel_op;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (access_done) prio_d <= ~gnt_d;
    end
  end

  // Next-state sequencing: read first for loads and sub-word stores, direct write for sw.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (sel_bad)              state_nxt = ERR;
          else if (sel_op == OP_SW) state_nxt = WR;
          else                      state_nxt = RD;
        end
      end
      RD:      state_nxt = op_q[3] ? MRG : RSP;
      RSP:     state_nxt = IDLE;
      MRG:     state_nxt = IDLE;
      WR:      state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory strobes and responses; everything is forced low while reset is asserted.
  always_comb begin
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    resp_ack   = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    if (!reset) begin
      case (state)
        RD: begin
          mem_re   = 1'b1;
          mem_addr = addr_q[MEM_AW+1:2];
        end
        RSP: begin
          resp_ack   = 1'b1;
          resp_rdata = load_format(op_q, addr_q[1:0], mem_rdata);
        end
        MRG: begin
          mem_we    = 1'b1;
          mem_addr  = addr_q[MEM_AW+1:2];
          mem_wdata = store_merge(op_q, addr_q[1:0], mem_rdata, wdata_q);
          resp_ack  = 1'b1;
        end
        WR: begin
          mem_we    = 1'b1;
          mem_addr  = addr_q[MEM_AW+1:2];
          mem_wdata = wdata_q;
          resp_ack  = 1'b1;
        end
        ERR: begin
          resp_ack = 1'b1;
          resp_err = 1'b1;
        end
        default: ;
      endcase
    end
    c_ack   = resp_ack & ~gnt_d;
    c_err   = resp_err & ~gnt_d;
    c_rdata = gnt_d ? 32'h0 : resp_rdata;
    d_ack   = resp_ack & gnt_d;
    d_err   = resp_err & gnt_d;
    d_rdata = gnt_d ? resp_rdata : 32'h0;
  end

endmodule
